// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: frame controller for an SPI slave.
// Sequences the external SIPO through one SS_n-framed transaction, decodes the
// command bit, flags a complete frame on rx_valid and serializes one byte of
// RAM read data onto MISO (MSB first) for a read-data frame.
module spi_slave_ctrl #(
    parameter int unsigned FRAME_W = 10,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              shift_en,
    output logic              rx_valid,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO
);

    localparam int unsigned BCW = $clog2(FRAME_W + 1);
    localparam int unsigned TCW = $clog2(DATA_W + 1);

    localparam logic [BCW-1:0] BC_LAST = BCW'(FRAME_W - 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(FRAME_W);
    localparam logic [TCW-1:0] TC_ONE  = TCW'(1);
    localparam logic [TCW-1:0] TC_FULL = TCW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BCW-1:0]    bit_cnt;
    logic [TCW-1:0]    tx_cnt;
    logic [DATA_W-1:0] tx_sreg;
    logic              rd_addr_ok;
    logic              in_frame;
    logic              frame_done;
    logic              tx_load;

    // Frame-state qualifiers shared by the counter and transmit paths
    always_comb begin
        in_frame   = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
        frame_done = in_frame && (bit_cnt == BC_LAST);
        tx_load    = (state_q == READ_DATA) && (bit_cnt == BC_FULL) &&
                     (tx_cnt == '0) && tx_valid && !SS_n;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and SIPO shift enable
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD: begin
                shift_en = 1'b1;
                if (SS_n) begin
                    state_d = IDLE;
                end else if (!MOSI) begin
                    state_d = WRITE;
                end else if (rd_addr_ok) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            default: begin
                shift_en = (bit_cnt < BC_FULL);
                if (SS_n) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Bit counter, frame-complete pulse and read-address tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_valid   <= 1'b0;
            rd_addr_ok <= 1'b0;
        end else begin
            // The last bit still completes the frame if SS_n rises on the same edge
            rx_valid <= frame_done;
            if (frame_done && (state_q == READ_ADD)) begin
                rd_addr_ok <= 1'b1;
            end else if (frame_done && (state_q == READ_DATA)) begin
                rd_addr_ok <= 1'b0;
            end
            if ((state_q != IDLE) && SS_n) begin
                bit_cnt <= '0;
            end else if (state_q == CHK_CMD) begin
                bit_cnt <= BCW'(1);
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // One-byte MISO serializer for read-data frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= '0;
            tx_sreg <= '0;
            MISO    <= 1'b0;
        end else if ((state_q != READ_DATA) || SS_n) begin
            tx_cnt  <= '0;
            tx_sreg <= '0;
            MISO    <= 1'b0;
        end else if (tx_load) begin
            // MSB goes straight to MISO; the remaining bits queue in tx_sreg
            MISO    <= tx_data[DATA_W-1];
            tx_sreg <= {tx_data[DATA_W-2:0], 1'b0};
            tx_cnt  <= TC_ONE;
        end else if ((tx_cnt != '0) && (tx_cnt != TC_FULL)) begin
            MISO    <= tx_sreg[DATA_W-1];
            tx_sreg <= {tx_sreg[DATA_W-2:0], 1'b0};
            tx_cnt  <= tx_cnt + 1'b1;
        end else begin
            MISO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: table-driven and randomized checks of spi_slave_ctrl.
// Each transaction starts in IDLE at cycle 0 with SS_n low; frame bits are on
// MOSI in cycles 1..FRAME_W (MSB first); 'a' is the first cycle SS_n is high.
// Expected outputs come from a transaction-level model of the frame rules.
module tb_spi_slave_ctrl;

    localparam int FW   = 10;
    localparam int DW   = 8;
    localparam int MAXC = 48;
    localparam int NVEC = 14;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          SS_n     = 1'b1;
    logic          MOSI     = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          shift_en;
    logic          rx_valid;
    logic          MISO;

    spi_slave_ctrl #(.FRAME_W(FW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .shift_en (shift_en),
        .rx_valid (rx_valid),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          st_ss   [MAXC];
    logic          st_mosi [MAXC];
    logic          st_txv  [MAXC];
    logic [DW-1:0] st_txd  [MAXC];
    logic [FW-1:0] sipo = '0;
    bit            model_addr_ok = 1'b0;

    typedef struct {
        logic [FW-1:0] frame;
        int            a;
        int            txv_at;
        logic [DW-1:0] txb;
        int            spur_at;
        bit            exp_rx;
        int            exp_start;
        logic [DW-1:0] exp_byte;
    } vec_t;

    vec_t vecs [NVEC];

    // Compare one observed value against its expectation
    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    // Default stimulus for one transaction: frame on MOSI, SS_n high from cycle a
    task automatic fill_stim(input logic [FW-1:0] frame, input int a);
        for (int k = 0; k < MAXC; k++) begin
            st_ss[k]   = (k >= a);
            st_mosi[k] = (k >= 1 && k <= FW) ? frame[FW-k] : 1'($urandom_range(0, 1));
            st_txv[k]  = 1'b0;
            st_txd[k]  = DW'($urandom);
        end
    endtask

    // Drive one transaction and check every cycle of it
    task automatic run_txn(input string tag, input logic [FW-1:0] frame, input int a,
                           input bit exp_rx, input int exp_start, input logic [DW-1:0] exp_byte);
        logic exp_sh, exp_rv, exp_mi;
        int   last_shift;
        last_shift = (a < FW) ? a : FW;
        for (int k = 0; k <= a + 1; k++) begin
            SS_n     = st_ss[k];
            MOSI     = st_mosi[k];
            tx_valid = st_txv[k];
            tx_data  = st_txd[k];
            @(negedge clk);
            exp_sh = (k >= 1) && (k <= last_shift);
            exp_rv = exp_rx && (k == FW + 1);
            exp_mi = 1'b0;
            if (exp_start >= 0 && k >= exp_start + 1 && k <= exp_start + DW && k <= a)
                exp_mi = exp_byte[DW-1-(k-exp_start-1)];
            chk({tag, " shift_en"}, k, 32'(shift_en), 32'(exp_sh));
            chk({tag, " rx_valid"}, k, 32'(rx_valid), 32'(exp_rv));
            chk({tag, " MISO"}, k, 32'(MISO), 32'(exp_mi));
            if (exp_rv) chk({tag, " sipo"}, k, 32'(sipo), 32'(frame));
            if (shift_en === 1'b1) sipo = {sipo[FW-2:0], MOSI};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [FW-1:0] frame;
        logic [DW-1:0] byt;
        int            a;
        int            sel;
        int            start;

        vecs[0]  = '{10'h0AA, 14, 12, 8'h11, 5,  1'b1, -1, 8'h00}; // write, spurious tx_valid
        vecs[1]  = '{10'h305, 13, 12, 8'h22, -1, 1'b1, -1, 8'h00}; // read-add
        vecs[2]  = '{10'h3F0, 24, 13, 8'hA5, 22, 1'b1, 13, 8'hA5}; // read-data, late tx_valid
        vecs[3]  = '{10'h3FF, 24, 12, 8'h5A, -1, 1'b1, -1, 8'h00}; // read without address
        vecs[4]  = '{10'h3AB, 6,  -1, 8'h00, -1, 1'b0, -1, 8'h00}; // abort after 6 bits
        vecs[5]  = '{10'h300, 26, 11, 8'h3C, 14, 1'b1, 11, 8'h3C}; // tx_valid mid-byte ignored
        vecs[6]  = '{10'h301, 12, -1, 8'h00, -1, 1'b1, -1, 8'h00}; // read-add
        vecs[7]  = '{10'h3AA, 15, 11, 8'hFF, -1, 1'b1, 11, 8'hFF}; // transmit cut short
        vecs[8]  = '{10'h155, 10, -1, 8'h00, -1, 1'b1, -1, 8'h00}; // SS_n rises on last bit
        vecs[9]  = '{10'h2C3, 10, -1, 8'h00, -1, 1'b1, -1, 8'h00}; // same, read-add
        vecs[10] = '{10'h2C3, 10, -1, 8'h00, -1, 1'b1, -1, 8'h00}; // same, read-data
        vecs[11] = '{10'h2FF, 20, 11, 8'h77, -1, 1'b1, -1, 8'h00}; // address was consumed
        vecs[12] = '{10'h0AA, 1,  -1, 8'h00, -1, 1'b0, -1, 8'h00}; // SS_n high in command cycle
        vecs[13] = '{10'h3C3, 22, 12, 8'h81, -1, 1'b1, 12, 8'h81}; // read-data

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset shift_en", 0, 32'(shift_en), 32'(0));
        chk("reset rx_valid", 0, 32'(rx_valid), 32'(0));
        chk("reset MISO", 0, 32'(MISO), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            fill_stim(vecs[i].frame, vecs[i].a);
            if (vecs[i].txv_at >= 0) begin
                st_txv[vecs[i].txv_at] = 1'b1;
                st_txd[vecs[i].txv_at] = vecs[i].txb;
            end
            if (vecs[i].spur_at >= 0) begin
                st_txv[vecs[i].spur_at] = 1'b1;
                st_txd[vecs[i].spur_at] = ~vecs[i].txb;
            end
            run_txn($sformatf("vec%0d", i), vecs[i].frame, vecs[i].a,
                    vecs[i].exp_rx, vecs[i].exp_start, vecs[i].exp_byte);
        end

        // Reset in the middle of a read frame clears the pending read address
        fill_stim(10'h3F1, 12);
        run_txn("rst_pre", 10'h3F1, 12, 1'b1, -1, 8'h00);
        fill_stim(10'h3FF, MAXC);
        for (int k = 0; k <= 6; k++) begin
            SS_n = st_ss[k];
            MOSI = st_mosi[k];
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst shift_en", 6, 32'(shift_en), 32'(0));
        chk("midrst rx_valid", 6, 32'(rx_valid), 32'(0));
        chk("midrst MISO", 6, 32'(MISO), 32'(0));
        SS_n = 1'b1;
        @(negedge clk);
        chk("midrst hold shift_en", 7, 32'(shift_en), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_stim(10'h3FF, 24);
        st_txv[12] = 1'b1;
        st_txd[12] = 8'h5A;
        run_txn("rst_post_add", 10'h3FF, 24, 1'b1, -1, 8'h00);
        fill_stim(10'h3C5, 24);
        st_txv[12] = 1'b1;
        st_txd[12] = 8'h96;
        run_txn("rst_post_data", 10'h3C5, 24, 1'b1, 12, 8'h96);
        model_addr_ok = 1'b0;

        // Randomized transactions against the transaction-level model
        for (int n = 0; n < 60; n++) begin
            frame = FW'($urandom);
            sel   = int'($urandom_range(0, 3));
            if (sel == 0)      a = int'($urandom_range(1, FW - 1));
            else if (sel == 1) a = FW;
            else               a = int'($urandom_range(FW + 1, FW + DW + 12));
            fill_stim(frame, a);
            for (int k = 0; k < MAXC; k++) st_txv[k] = ($urandom_range(0, 3) == 0);
            start = -1;
            if (frame[FW-1] && model_addr_ok && a > FW) begin
                for (int k = FW + 1; k < a; k++) begin
                    if (start < 0 && st_txv[k]) start = k;
                end
            end
            byt = (start >= 0) ? st_txd[start] : 8'h00;
            run_txn($sformatf("rnd%0d", n), frame, a, (a >= FW), start, byt);
            if (a >= FW && frame[FW-1]) begin
                if (model_addr_ok) model_addr_ok = 1'b0;  // read-data frame consumes the address
                else               model_addr_ok = 1'b1;  // read-address frame supplies one
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
